// File: rtl/ipsxe_fft_ctrl_pkg.sv
// Shared types and constants for the FFT frame sequencer: FSM states and config words.
package ipsxe_fft_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG      = 3'd1,
    SEND     = 3'd2,
    WAIT_OUT = 3'd3,
    DONE     = 3'd4
  } ctrl_state_e;

  localparam logic [7:0] CFG_FWD = 8'h01;
  localparam logic [7:0] CFG_INV = 8'h00;

  function automatic logic [7:0] cfg_word(input logic inverse);
    return inverse ? CFG_INV : CFG_FWD;
  endfunction

endpackage

// File: rtl/ipsxe_fft_len_chk.sv
// Output-frame checker: counts core output beats and flags a good frame or a length/tlast error.
module ipsxe_fft_len_chk
  import ipsxe_fft_ctrl_pkg::*;
#(
  parameter int LOG2_FFT_LEN = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic beat_valid,
  input  logic beat_last,
  output logic frame_ok,
  output logic len_err
);

  localparam logic [LOG2_FFT_LEN-1:0] LAST_BEAT = {LOG2_FFT_LEN{1'b1}};

  logic [LOG2_FFT_LEN-1:0] cnt_r;
  logic                    at_last_s;

  // Classify the current beat against the running count; tlast must land exactly on beat N-1.
  always_comb begin
    frame_ok  = 1'b0;
    len_err   = 1'b0;
    at_last_s = (cnt_r == LAST_BEAT);
    if (en && beat_valid) begin
      if (beat_last && at_last_s) begin
        frame_ok = 1'b1;
      end else if (beat_last || at_last_s) begin
        len_err = 1'b1;
      end else begin
        frame_ok = 1'b0;
      end
    end else begin
      frame_ok = 1'b0;
    end
  end

  // Beat counter; held at zero whenever checking is disabled so each run starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!en) begin
      cnt_r <= '0;
    end else if (beat_valid) begin
      if (frame_ok || len_err) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ipsxe_fft_frame_ctrl.sv
// FFT test sequencer: config write, ramp frame streaming, output frame checking, status reporting.
// Optional output watchdog is built when IPSXE_FFT_TIMEOUT_EN is defined.
module ipsxe_fft_frame_ctrl
  import ipsxe_fft_ctrl_pkg::*;
#(
  parameter int LOG2_FFT_LEN = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_FRAMES   = 4
`ifdef IPSXE_FFT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic                    i_inverse,
  output logic                    o_axi4s_cfg_tvalid,
  output logic [7:0]              o_axi4s_cfg_tdata,
  input  logic                    i_axi4s_cfg_tready,
  output logic                    o_axi4s_data_tvalid,
  output logic [2*DATA_WIDTH-1:0] o_axi4s_data_tdata,
  output logic                    o_axi4s_data_tlast,
  input  logic                    i_axi4s_data_tready,
  input  logic                    i_axi4s_out_tvalid,
  input  logic                    i_axi4s_out_tlast,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [7:0]              o_frame_cnt
);

  localparam logic [LOG2_FFT_LEN-1:0] LAST_IDX = {LOG2_FFT_LEN{1'b1}};

  ctrl_state_e             state_r;
  logic                    start_d_r;
  logic                    cfg_tvalid_r;
  logic [7:0]              cfg_tdata_r;
  logic                    data_tvalid_r;
  logic [LOG2_FFT_LEN-1:0] idx_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    err_r;
  logic [7:0]              frame_cnt_r;

  logic start_s;
  logic cfg_hs_s;
  logic data_hs_s;
  logic last_idx_s;
  logic chk_en_s;
  logic more_frames_s;
  logic frame_ok_s;
  logic len_err_s;
  logic timeout_s;
  logic fail_s;
  logic finish_s;

  assign start_s       = i_start & ~start_d_r;
  assign cfg_hs_s      = cfg_tvalid_r & i_axi4s_cfg_tready;
  assign data_hs_s     = data_tvalid_r & i_axi4s_data_tready;
  assign last_idx_s    = (idx_r == LAST_IDX);
  assign chk_en_s      = (state_r == CFG) || (state_r == SEND) || (state_r == WAIT_OUT);
  assign more_frames_s = ({1'b0, frame_cnt_r} + 9'd1) < 9'(NUM_FRAMES);

  ipsxe_fft_len_chk #(
    .LOG2_FFT_LEN (LOG2_FFT_LEN)
  ) u_len_chk (
    .clk        (i_clk),
    .rst_n      (i_rstn),
    .en         (chk_en_s),
    .beat_valid (i_axi4s_out_tvalid),
    .beat_last  (i_axi4s_out_tlast),
    .frame_ok   (frame_ok_s),
    .len_err    (len_err_s)
  );

`ifdef IPSXE_FFT_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog_r;

  assign timeout_s = (state_r == WAIT_OUT) && !i_axi4s_out_tvalid && (wdog_r == WDOG_LIMIT);

  // Watchdog: counts silent WAIT_OUT cycles, any output beat restarts it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wdog_r <= 16'd0;
    end else if ((state_r != WAIT_OUT) || i_axi4s_out_tvalid) begin
      wdog_r <= 16'd0;
    end else begin
      wdog_r <= wdog_r + 16'd1;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // A frame completing on the same edge as the final input handshake ends the run from SEND.
  assign fail_s   = len_err_s | timeout_s;
  assign finish_s = frame_ok_s && !more_frames_s &&
                    ((state_r == WAIT_OUT) || ((state_r == SEND) && data_hs_s && last_idx_s));

  // Main sequencer with registered status and handshake outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r       <= IDLE;
      start_d_r     <= 1'b0;
      cfg_tvalid_r  <= 1'b0;
      cfg_tdata_r   <= 8'h00;
      data_tvalid_r <= 1'b0;
      idx_r         <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      frame_cnt_r   <= 8'd0;
    end else begin
      start_d_r <= i_start;
      if (frame_ok_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if (fail_s || finish_s) begin
        state_r       <= DONE;
        busy_r        <= 1'b0;
        done_r        <= 1'b1;
        err_r         <= fail_s;
        cfg_tvalid_r  <= 1'b0;
        data_tvalid_r <= 1'b0;
        idx_r         <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start_s) begin
              done_r       <= 1'b0;
              err_r        <= 1'b0;
              frame_cnt_r  <= 8'd0;
              cfg_tdata_r  <= cfg_word(i_inverse);
              cfg_tvalid_r <= 1'b1;
              busy_r       <= 1'b1;
              idx_r        <= '0;
              state_r      <= CFG;
            end else begin
              state_r <= IDLE;
            end
          end
          CFG: begin
            if (cfg_hs_s) begin
              cfg_tvalid_r  <= 1'b0;
              data_tvalid_r <= 1'b1;
              state_r       <= SEND;
            end else begin
              state_r <= CFG;
            end
          end
          SEND: begin
            if (data_hs_s && last_idx_s) begin
              idx_r <= '0;
              if (!frame_ok_s) begin
                data_tvalid_r <= 1'b0;
                state_r       <= WAIT_OUT;
              end else begin
                state_r <= SEND;
              end
            end else if (data_hs_s) begin
              idx_r <= idx_r + 1'b1;
            end else begin
              state_r <= SEND;
            end
          end
          WAIT_OUT: begin
            if (frame_ok_s) begin
              data_tvalid_r <= 1'b1;
              state_r       <= SEND;
            end else begin
              state_r <= WAIT_OUT;
            end
          end
          DONE: begin
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_axi4s_cfg_tvalid  = cfg_tvalid_r;
  assign o_axi4s_cfg_tdata   = cfg_tdata_r;
  assign o_axi4s_data_tvalid = data_tvalid_r;
  assign o_axi4s_data_tdata  = {{DATA_WIDTH{1'b0}}, DATA_WIDTH'(idx_r)};
  assign o_axi4s_data_tlast  = data_tvalid_r & last_idx_s;
  assign o_busy              = busy_r;
  assign o_done              = done_r;
  assign o_err               = err_r;
  assign o_frame_cnt         = frame_cnt_r;

endmodule
